hazard_stall_unit: RTL and testbench

- Hazard detection and stall/flush controller for the 5-stage MIPS pipeline. Sits in ID, alongside the IF_ID register and directly upstream of the ID/EX pipeline register.
- Compares the source registers of the instruction in IF_ID against the destinations in flight in ID/EX.
- Drives the PC write enable, the IF_ID write enable and flush, and a bubble select that zeroes the control bits latched into ID/EX.
- Holds a small FSM for multi-cycle stalls: load followed by a branch that compares in ID.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_reg_match.sv | 15 +
 rtl/hazard_stall_unit.sv | 113 +++++++++++
 tb/tb_hazard_stall_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller:
// FSM encoding, the $0 register address and the enable/flush/bubble patterns.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int         ADDR_W_DEF = 5;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic flush;
        logic bubble;
    } ctrl_t;

    localparam ctrl_t PAT_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1, flush: 1'b0, bubble: 1'b0};
    localparam ctrl_t PAT_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, flush: 1'b0, bubble: 1'b1};
    localparam ctrl_t PAT_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, flush: 1'b1, bubble: 0};
    localparam ctrl_t PAT_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, flush: 1'b1, bubble: 1'b1};

endpackage

// File: rtl/hazard_reg_match.sv
// Register-address comparator: true when both addresses are equal and not $0,
// since writes to $0 are discarded and can never create a dependency.
module hazard_reg_match
    import hazard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic              match
);

    assign match = (a == b) && (a != ADDR_W'(REG_ZERO));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch hazard detection with a RUN/STALL FSM for load->branch stalls.
// Optional saturating stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W             = ADDR_W_DEF,
    parameter int LOAD_BRANCH_STALLS = 2,
    parameter int CNT_W              = 32
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              ID_EX_MemRead_in,
    input  logic              ID_EX_RegWrite_in,
    input  logic [ADDR_W-1:0] ID_EX_Rt_in,
    input  logic [ADDR_W-1:0] ID_EX_Rd_in,
    input  logic [ADDR_W-1:0] IF_ID_Rs_in,
    input  logic [ADDR_W-1:0] IF_ID_Rt_in,
    input  logic              IF_ID_UsesRt_in,
    input  logic              IF_ID_Branch_in,
    input  logic              Branch_taken_in,
    output logic              PC_Write_out,
    output logic              IF_ID_Write_out,
    output logic              IF_ID_Flush_out,
    output logic              Ctrl_Bubble_out,
    output logic              Stall_State_out,
    output logic [CNT_W-1:0]  Stall_Cycles_out,
    output logic [CNT_W-1:0]  Flush_Count_out
);

    logic   ld_rs, ld_rt, alu_rs, alu_rt;
    logic   lu, br_alu, br_ld, haz;
    state_t state;
    logic [1:0] cnt;
    ctrl_t  pat;

    hazard_reg_match #(.ADDR_W(ADDR_W)) u_ld_rs  (.a(ID_EX_Rt_in), .b(IF_ID_Rs_in), .match(ld_rs));
    hazard_reg_match #(.ADDR_W(ADDR_W)) u_ld_rt  (.a(ID_EX_Rt_in), .b(IF_ID_Rt_in), .match(ld_rt));
    hazard_reg_match #(.ADDR_W(ADDR_W)) u_alu_rs (.a(ID_EX_Rd_in), .b(IF_ID_Rs_in), .match(alu_rs));
    hazard_reg_match #(.ADDR_W(ADDR_W)) u_alu_rt (.a(ID_EX_Rd_in), .b(IF_ID_Rt_in), .match(alu_rt));

    assign lu     = ID_EX_MemRead_in && (ld_rs || (IF_ID_UsesRt_in && ld_rt));
    assign br_alu = IF_ID_Branch_in && ID_EX_RegWrite_in && !ID_EX_MemRead_in && (alu_rs || alu_rt);
    assign br_ld  = lu && IF_ID_Branch_in;
    assign haz    = lu || br_alu;

    // Stall wins over flush; in STALL the branch operands are not valid yet.
    always_comb begin
        pat = PAT_RUN;
        if (reset_in)
            pat = PAT_RESET;
        else if ((state == STALL) || haz)
            pat = PAT_STALL;
        else if (Branch_taken_in)
            pat = PAT_FLUSH;
    end

    assign PC_Write_out    = pat.pc_write;
    assign IF_ID_Write_out = pat.if_id_write;
    assign IF_ID_Flush_out = pat.flush;
    assign Ctrl_Bubble_out = pat.bubble;
    assign Stall_State_out = (state == STALL);

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (br_ld && (LOAD_BRANCH_STALLS > 1)) begin
                        state <= STALL;
                        cnt   <= 2'(LOAD_BRANCH_STALLS - 1);
                    end
                end
                STALL: begin
                    if (cnt <= 2'd1) begin
                        state <= RUN;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pat.pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (pat.flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

    assign Stall_Cycles_out = stall_cycles;
    assign Flush_Count_out  = flush_count;
`else
    assign Stall_Cycles_out = '0;
    assign Flush_Count_out  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed test-plan steps followed by
// random traffic, all compared against a cycle-level reference model.
module tb_hazard_stall_unit;

    localparam int LBS = 2;
    localparam int AW  = 5;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          memrd = 0, regwr = 0, uses_rt = 0, branch = 0, taken = 0;
    logic [AW-1:0] ex_rt = 0, ex_rd = 0, id_rs = 0, id_rt = 0;
    logic          pc_write, if_id_write, if_id_flush, bubble, stall_state;
    logic [CW-1:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    // reference model: number of forced stall cycles still owed, plus event counts
    int          m_extra = 0;
    int unsigned m_stalls = 0, m_flushes = 0;
    logic        e_pc, e_ifw, e_fl, e_bub, e_ss, e_brld;

    hazard_stall_unit #(.ADDR_W(AW), .LOAD_BRANCH_STALLS(LBS), .CNT_W(CW)) dut (
        .clk(clk), .reset_in(reset_in),
        .ID_EX_MemRead_in(memrd), .ID_EX_RegWrite_in(regwr),
        .ID_EX_Rt_in(ex_rt), .ID_EX_Rd_in(ex_rd),
        .IF_ID_Rs_in(id_rs), .IF_ID_Rt_in(id_rt),
        .IF_ID_UsesRt_in(uses_rt), .IF_ID_Branch_in(branch), .Branch_taken_in(taken),
        .PC_Write_out(pc_write), .IF_ID_Write_out(if_id_write), .IF_ID_Flush_out(if_id_flush),
        .Ctrl_Bubble_out(bubble), .Stall_State_out(stall_state),
        .Stall_Cycles_out(stall_cycles), .Flush_Count_out(flush_count)
    );

    always #5 clk = ~clk;

    function automatic bit dep(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && (a != 0);
    endfunction

    task automatic compute_exp();
        bit lu, bra, haz;
        lu  = memrd && (dep(ex_rt, id_rs) || (uses_rt && dep(ex_rt, id_rt)));
        bra = branch && regwr && !memrd && (dep(ex_rd, id_rs) || dep(ex_rd, id_rt));
        haz = lu || bra;
        e_brld = lu && branch;
        e_ss   = (m_extra > 0) && !reset_in;
        if (reset_in)                 {e_pc, e_ifw, e_fl, e_bub} = 4'b0011;
        else if (m_extra > 0 || haz)  {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
        else if (taken)               {e_pc, e_ifw, e_fl, e_bub} = 4'b1110;
        else                          {e_pc, e_ifw, e_fl, e_bub} = 4'b1100;
    endtask

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string step);
        compute_exp();
        check({step, ".pc_write"},    CW'(pc_write),    CW'(e_pc));
        check({step, ".if_id_write"}, CW'(if_id_write), CW'(e_ifw));
        check({step, ".flush"},       CW'(if_id_flush), CW'(e_fl));
        check({step, ".bubble"},      CW'(bubble),      CW'(e_bub));
        check({step, ".stall_state"}, CW'(stall_state), CW'(e_ss));
`ifdef HAZARD_PERF_CNT_EN
        check({step, ".stall_cycles"}, stall_cycles, CW'(m_stalls));
        check({step, ".flush_count"},  flush_count,  CW'(m_flushes));
`else
        check({step, ".stall_cycles"}, stall_cycles, '0);
        check({step, ".flush_count"},  flush_count,  '0);
`endif
    endtask

    task automatic model_reset();
        m_extra   = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // expectations were computed from the inputs held across this edge
    task automatic advance();
        @(posedge clk);
        if (!reset_in) begin
            if (!e_pc) m_stalls++;
            if (e_fl)  m_flushes++;
            if (m_extra > 0) m_extra--;
            else if (e_brld && LBS > 1) m_extra = LBS - 1;
        end
    endtask

    task automatic drive(input logic mr, input logic rw, input int ert, input int erd,
                         input int rs, input int rt, input logic ur, input logic br, input logic tk);
        memrd = mr; regwr = rw; ex_rt = AW'(ert); ex_rd = AW'(erd);
        id_rs = AW'(rs); id_rt = AW'(rt); uses_rt = ur; branch = br; taken = tk;
    endtask

    task automatic step(input string name, input logic mr, input logic rw, input int ert, input int erd,
                        input int rs, input int rt, input logic ur, input logic br, input logic tk);
        @(negedge clk);
        drive(mr, rw, ert, erd, rs, rt, ur, br, tk);
        #1;
        check_outputs(name);
        advance();
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        reset_in = 1'b0;

        // load-use: one stall then free-running
        step("lu_stall", 1, 1, 2, 2, 2, 7, 0, 0, 0);
        step("lu_after", 0, 0, 0, 0, 2, 7, 0, 0, 0);
        // $0 never hazards
        step("zero_reg", 1, 1, 0, 0, 0, 0, 1, 0, 0);
        // load -> branch: two stalls, taken ignored in the second
        step("ldbr_1", 1, 1, 3, 3, 1, 3, 1, 1, 0);
        step("ldbr_2", 0, 0, 0, 0, 1, 3, 1, 1, 1);
        check("ldbr_2.state_const", CW'(m_extra), '0);
        step("ldbr_run", 0, 0, 0, 0, 1, 3, 1, 1, 0);
        // ALU -> branch: one stall, then the taken branch flushes
        step("albr_1", 0, 1, 9, 4, 4, 5, 1, 1, 0);
        step("albr_flush", 0, 0, 0, 0, 4, 5, 1, 1, 1);

        // reset asserted in the middle of STALL
        step("mid_enter", 1, 1, 6, 6, 6, 0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        reset_in = 1'b1;
        model_reset();
        #1;
        check_outputs("mid_reset");
        advance();
        @(negedge clk);
        reset_in = 1'b0;
        #1;
        check_outputs("post_reset");
        advance();
        step("post_reset_run", 0, 0, 0, 0, 6, 6, 1, 1, 0);

        // three load-use stalls, two taken flushes from a clean reset
        @(negedge clk);
        reset_in = 1'b1;
        model_reset();
        @(negedge clk);
        reset_in = 1'b0;
        step("perf_lu1", 1, 1, 8, 8, 8, 0, 0, 0, 0);
        step("perf_run", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("perf_lu2", 1, 1, 8, 8, 1, 8, 1, 0, 0);
        step("perf_lu3", 1, 1, 9, 9, 9, 9, 0, 0, 1);
        step("perf_tk1", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("perf_tk2", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_outputs("perf_totals");
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_3", stall_cycles, 32'd3);
        check("perf_flush_2", flush_count,  32'd2);
`endif
        advance();

        // random traffic on a small register pool to hit matches often
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset_in = ($urandom_range(0, 49) == 0);
            if (reset_in) model_reset();
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            #1;
            check_outputs("random");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
